// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: sequences multi-cycle SRAM loads/stores and stalls the pipeline meanwhile.
// Optional LAST_WRITE_BYPASS_EN serves a load that hits the last completed store without an SRAM access.
module mem_access_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        RegWriteIn,
  input  logic        MemotoRegIn,
  input  logic        MemWriteIn,
  input  logic        MemReadIn,
  input  logic [15:0] ResultIn,
  input  logic [15:0] DataInIn,
  input  logic [3:0]  RegWriteIndexIn,
  output logic [15:0] RamAddr,
  output logic [15:0] RamDataOut,
  output logic        RamDataOE,
  input  logic [15:0] RamDataIn,
  output logic        RamCE_n,
  output logic        RamOE_n,
  output logic        RamWE_n,
  output logic        MemStall,
  output logic        RegWriteOut,
  output logic        MemotoRegOut,
  output logic [15:0] ResultOut,
  output logic [15:0] ReadData,
  output logic [3:0]  RegWriteIndexOut
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} stateT;

  stateT       state;
  stateT       stateNext;
  logic [3:0]  waitCnt;
  logic [3:0]  waitCntNext;
  logic        lastWait;
  logic        bypassHit;
  logic [15:0] bypassData;
  logic        loadReq;

  assign lastWait = (waitCnt == 4'd0);
  assign loadReq  = MemReadIn & ~MemWriteIn;

`ifdef LAST_WRITE_BYPASS_EN
  logic [15:0] lastWrAddr;
  logic [15:0] lastWrData;
  logic        lastWrValid;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)
      lastWrValid <= 1'b0;
    else if (state == WRITE && lastWait)
      lastWrValid <= 1'b1;
  end

  // Record contents are qualified by lastWrValid, so they need no reset.
  always_ff @(posedge Clk) begin
    if (state == WRITE && lastWait) begin
      lastWrAddr <= RamAddr;
      lastWrData <= RamDataOut;
    end
  end

  assign bypassHit  = lastWrValid && (ResultIn == lastWrAddr);
  assign bypassData = lastWrData;
`else
  assign bypassHit  = 1'b0;
  assign bypassData = 16'h0000;
`endif

  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    MemStall    = 1'b0;
    RamCE_n     = 1'b1;
    RamOE_n     = 1'b1;
    RamWE_n     = 1'b1;
    RamDataOE   = 1'b0;
    case (state)
      IDLE: begin
        if (MemWriteIn) begin
          MemStall    = 1'b1;
          stateNext   = WRITE;
          waitCntNext = WAIT_LOAD;
        end else if (MemReadIn) begin
          MemStall = 1'b1;
          if (bypassHit) begin
            stateNext = DONE;
          end else begin
            stateNext   = READ;
            waitCntNext = WAIT_LOAD;
          end
        end
      end
      READ: begin
        MemStall = 1'b1;
        RamCE_n  = 1'b0;
        RamOE_n  = 1'b0;
        if (lastWait) stateNext = DONE;
        else          waitCntNext = waitCnt - 4'd1;
      end
      WRITE: begin
        MemStall  = 1'b1;
        RamCE_n   = 1'b0;
        RamWE_n   = 1'b0;
        RamDataOE = 1'b1;
        if (lastWait) stateNext = DONE;
        else          waitCntNext = waitCnt - 4'd1;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= IDLE;
      waitCnt    <= 4'd0;
      RamAddr    <= 16'h0000;
      RamDataOut <= 16'h0000;
      ReadData   <= 16'h0000;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
      if (state == IDLE && stateNext != IDLE) begin
        RamAddr    <= ResultIn;
        RamDataOut <= DataInIn;
      end
      if (state == READ && lastWait)
        ReadData <= RamDataIn;
      else if (state == IDLE && loadReq && bypassHit)
        ReadData <= bypassData;
    end
  end

  // Stalled cycles become bubbles toward write-back.
  assign RegWriteOut      = RegWriteIn & ~MemStall;
  assign MemotoRegOut     = MemotoRegIn & ~MemStall;
  assign ResultOut        = ResultIn;
  assign RegWriteIndexOut = RegWriteIndexIn;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed and random loads/stores checked against a transaction-level model.
module tb_mem_access_ctrl;

  localparam int WAIT_CYCLES = 2;

  logic        Clk;
  logic        Rst_n;
  logic        RegWriteIn;
  logic        MemotoRegIn;
  logic        MemWriteIn;
  logic        MemReadIn;
  logic [15:0] ResultIn;
  logic [15:0] DataInIn;
  logic [3:0]  RegWriteIndexIn;
  logic [15:0] RamAddr;
  logic [15:0] RamDataOut;
  logic        RamDataOE;
  logic [15:0] RamDataIn;
  logic        RamCE_n;
  logic        RamOE_n;
  logic        RamWE_n;
  logic        MemStall;
  logic        RegWriteOut;
  logic        MemotoRegOut;
  logic [15:0] ResultOut;
  logic [15:0] ReadData;
  logic [3:0]  RegWriteIndexOut;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [15:0] refMem [logic [15:0]];
  logic [15:0] lastRead = 16'h0000;
  bit          bypValid = 1'b0;
  logic [15:0] bypAddr  = 16'h0000;

  // Behavioural SRAM attached to the DUT
  logic [15:0] sram   [0:65535];
  bit          sramWr [0:65535];

  mem_access_ctrl #(.WAIT_CYCLES(WAIT_CYCLES)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .RegWriteIn(RegWriteIn), .MemotoRegIn(MemotoRegIn),
    .MemWriteIn(MemWriteIn), .MemReadIn(MemReadIn), .ResultIn(ResultIn), .DataInIn(DataInIn),
    .RegWriteIndexIn(RegWriteIndexIn), .RamAddr(RamAddr), .RamDataOut(RamDataOut),
    .RamDataOE(RamDataOE), .RamDataIn(RamDataIn), .RamCE_n(RamCE_n), .RamOE_n(RamOE_n),
    .RamWE_n(RamWE_n), .MemStall(MemStall), .RegWriteOut(RegWriteOut),
    .MemotoRegOut(MemotoRegOut), .ResultOut(ResultOut), .ReadData(ReadData),
    .RegWriteIndexOut(RegWriteIndexOut)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [15:0] initWord(input logic [15:0] a);
    return (a == 16'h0040) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  function automatic logic [15:0] refRead(input logic [15:0] a);
    return refMem.exists(a) ? refMem[a] : initWord(a);
  endfunction

  always @(negedge Clk)
    RamDataIn <= (!RamCE_n && !RamOE_n) ?
                 (sramWr[RamAddr] ? sram[RamAddr] : initWord(RamAddr)) : 16'hDEAD;

  always @(posedge Clk) begin
    if (Rst_n && !RamCE_n && !RamWE_n) begin
      sram[RamAddr]   <= RamDataOut;
      sramWr[RamAddr] <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idleCycle(input bit rw);
    MemWriteIn      = 1'b0;
    MemReadIn       = 1'b0;
    RegWriteIn      = rw;
    MemotoRegIn     = 1'($urandom_range(0, 1));
    ResultIn        = 16'($urandom);
    DataInIn        = 16'($urandom);
    RegWriteIndexIn = 4'($urandom);
    @(negedge Clk);
    check("idle_stall", MemStall, 0);
    check("idle_regwrite", RegWriteOut, rw);
    check("idle_m2r", MemotoRegOut, MemotoRegIn);
    check("idle_strobes", {RamCE_n, RamOE_n, RamWE_n, RamDataOE}, 4'b1110);
    check("idle_result", ResultOut, ResultIn);
    check("idle_index", RegWriteIndexOut, RegWriteIndexIn);
    check("idle_readdata", ReadData, lastRead);
    @(posedge Clk); #1;
  endtask

  // One memory instruction, held until the release cycle; called 1 time unit after a rising edge.
  task automatic doAccess(input bit wr, input bit rd, input logic [15:0] addr, input logic [15:0] data);
    bit          byp;
    bit          loadOnly;
    bit          busy;
    int          expStall;
    logic [15:0] newRead;
    byp      = 1'b0;
    loadOnly = rd && !wr;
`ifdef LAST_WRITE_BYPASS_EN
    byp = loadOnly && bypValid && (addr == bypAddr);
`endif
    expStall = byp ? 1 : 1 + WAIT_CYCLES;
    newRead  = loadOnly ? refRead(addr) : lastRead;

    MemWriteIn      = wr;
    MemReadIn       = rd;
    ResultIn        = addr;
    DataInIn        = data;
    RegWriteIn      = 1'($urandom_range(0, 1));
    MemotoRegIn     = rd;
    RegWriteIndexIn = 4'($urandom);

    for (int c = 1; c <= expStall + 1; c++) begin
      @(negedge Clk);
      busy = (c >= 2) && (c <= expStall) && !byp;
      check("stall", MemStall, c <= expStall);
      check("bubble_rw", RegWriteOut, (c <= expStall) ? 1'b0 : RegWriteIn);
      check("bubble_m2r", MemotoRegOut, (c <= expStall) ? 1'b0 : MemotoRegIn);
      check("ce_n", RamCE_n, !busy);
      check("oe_n", RamOE_n, !(busy && loadOnly));
      check("we_n", RamWE_n, !(busy && wr));
      check("data_oe", RamDataOE, busy && wr);
      if (busy) check("ram_addr", RamAddr, addr);
      if (busy && wr) check("ram_wdata", RamDataOut, data);
      check("readdata", ReadData, (c <= expStall) ? lastRead : newRead);
    end
    check("pass_result", ResultOut, addr);
    check("pass_index", RegWriteIndexOut, RegWriteIndexIn);
    @(posedge Clk); #1;
    MemWriteIn = 1'b0;
    MemReadIn  = 1'b0;

    if (wr) begin
      refMem[addr] = data;
      bypValid     = 1'b1;
      bypAddr      = addr;
    end
    lastRead = newRead;
  endtask

  logic [15:0] a;
  int          kind;

  initial begin
    Rst_n = 1'b0; RegWriteIn = 1'b0; MemotoRegIn = 1'b0; MemWriteIn = 1'b0; MemReadIn = 1'b0;
    ResultIn = 16'h0000; DataInIn = 16'h0000; RegWriteIndexIn = 4'h0;
    #1;
    check("rst_strobes", {RamCE_n, RamOE_n, RamWE_n, RamDataOE}, 4'b1110);
    check("rst_addr", RamAddr, 16'h0000);
    check("rst_wdata", RamDataOut, 16'h0000);
    check("rst_readdata", ReadData, 16'h0000);
    check("rst_stall", MemStall, 0);
    @(posedge Clk); @(posedge Clk); #1;
    Rst_n = 1'b1;

    idleCycle(1'b1);
    doAccess(1'b0, 1'b1, 16'h0040, 16'h0000);
    idleCycle(1'b0);
    doAccess(1'b1, 1'b0, 16'h0010, 16'h1234);
    doAccess(1'b0, 1'b1, 16'h0010, 16'h0000);
    doAccess(1'b1, 1'b1, 16'h0020, 16'h7777);
    idleCycle(1'b1);
    doAccess(1'b1, 1'b0, 16'h0008, 16'hA5A5);
    doAccess(1'b0, 1'b1, 16'h0008, 16'h0000);
    doAccess(1'b0, 1'b1, 16'h0020, 16'h0000);

    // Reset during the second READ cycle
    MemReadIn = 1'b1; MemWriteIn = 1'b0; ResultIn = 16'h0123;
    @(negedge Clk);
    check("mid_stall", MemStall, 1);
    @(posedge Clk); @(negedge Clk);
    check("mid_oe1", RamOE_n, 0);
    @(posedge Clk); #2;
    check("mid_oe2", RamOE_n, 0);
    Rst_n = 1'b0;
    #1;
    check("abort_strobes", {RamCE_n, RamOE_n, RamWE_n, RamDataOE}, 4'b1110);
    check("abort_readdata", ReadData, 16'h0000);
    check("abort_addr", RamAddr, 16'h0000);
    check("abort_idle_stall", MemStall, 1);
    @(negedge Clk);
    check("abort_quiet", {RamCE_n, RamOE_n, RamWE_n}, 3'b111);
    lastRead = 16'h0000;
    bypValid = 1'b0;
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    doAccess(1'b0, 1'b1, 16'h0123, 16'h0000);

    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 4));
      a = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 7) * 8) : 16'($urandom);
      case (kind)
        0:       idleCycle(1'($urandom_range(0, 1)));
        1, 2:    doAccess(1'b0, 1'b1, a, 16'($urandom));
        3:       doAccess(1'b1, 1'b0, a, 16'($urandom));
        default: doAccess(1'b1, 1'b1, a, 16'($urandom));
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, SRAM access cycles per transfer (legal 1..15).
REQ-002 SHALL have ports:
- Clk  in  1  clock, all state on rising edge
- Rst_n  in  1  asynchronous active-low reset
- RegWriteIn  in  1  pipeline register-write flag
- MemotoRegIn  in  1  pipeline mem-to-reg select
- MemWriteIn  in  1  store request
- MemReadIn  in  1  load request
- ResultIn  in  16  ALU result / word address
- DataInIn  in  16  store data
- RegWriteIndexIn  in  4  destination register
- RamAddr  out  16  SRAM address
- RamDataOut  out  16  SRAM write data
- RamDataOE  out  1  drive SRAM data bus
- RamDataIn  in  16  SRAM read data
- RamCE_n  out  1  chip enable, active low
- RamOE_n  out  1  output enable, active low
- RamWE_n  out  1  write enable, active low
- MemStall  out  1  freeze upstream pipeline
- RegWriteOut  out  1  to write-back register
- MemotoRegOut  out  1  to write-back register
- ResultOut  out  16  ResultIn pass-through
- ReadData  out  16  registered load data
- RegWriteIndexOut  out  4  pass-through

Function
REQ-003 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-004 IDLE: MemWriteIn=1 -> WRITE; else MemReadIn=1 -> READ; else stay; on leaving, latch ResultIn to RamAddr and DataInIn to RamDataOut, load wait counter with WAIT_CYCLES-1.
REQ-005 MemWriteIn and MemReadIn both 1 SHALL be treated as write only; ReadData unchanged.
REQ-006 READ: RamCE_n=0, RamOE_n=0, RamWE_n=1, RamDataOE=0 for exactly WAIT_CYCLES cycles; on the last cycle ReadData <= RamDataIn; then DONE.
REQ-007 WRITE: RamCE_n=0, RamWE_n=0, RamOE_n=1, RamDataOE=1 for exactly WAIT_CYCLES cycles; then DONE.
REQ-008 DONE: all RAM strobes high, RamDataOE=0, unconditional transition to IDLE after one cycle.
REQ-009 In IDLE and DONE, RamCE_n, RamOE_n, RamWE_n SHALL be 1 and RamDataOE 0.
REQ-010 MemStall SHALL be combinational: 1 when (IDLE and (MemReadIn or MemWriteIn)) or READ or WRITE; 0 in DONE.
REQ-011 Stall length SHALL be 1+WAIT_CYCLES cycles per access, with DONE as the release cycle; non-memory instructions SHALL never stall.
REQ-012 Upstream inputs are held constant while MemStall=1; the request still visible in DONE SHALL NOT retrigger.
REQ-013 RegWriteOut and MemotoRegOut SHALL equal their inputs ANDed with ~MemStall (bubble while stalled); ResultOut and RegWriteIndexOut pass through unconditionally.
REQ-014 ReadData SHALL hold its value until the next completed load.

Reset
REQ-015 Rst_n=0 SHALL immediately force IDLE, wait counter 0, RamAddr=0, RamDataOut=0, ReadData=0, RamCE_n=RamOE_n=RamWE_n=1, RamDataOE=0, independent of Clk.
REQ-016 Reset mid-access SHALL abort the transfer with no further strobe activity; a request present after Rst_n rises SHALL start fresh from IDLE.

Configuration
REQ-017 Macro LAST_WRITE_BYPASS_EN defined: module SHALL record address/data of each completed write plus a valid bit (reset 0); a read in IDLE whose ResultIn equals the recorded address with valid=1 SHALL load ReadData from the recorded data, go directly to DONE, stall 1 cycle, and issue no SRAM access.
REQ-018 Macro undefined: no record storage; every read accesses SRAM per REQ-006.

Verification
REQ-019 WAIT_CYCLES=2, load addr 0x0040, RamDataIn=0xBEEF -> MemStall high 3 cycles, RamOE_n low 2 cycles, ReadData=0xBEEF in DONE.
REQ-020 Store 0x1234 to 0x0010 -> RamWE_n low exactly 2 cycles, RamDataOE=1, RamDataOut=0x1234, RamAddr=0x0010, MemStall 3 cycles.
REQ-021 Non-memory instruction, RegWriteIn=1 -> MemStall=0, RegWriteOut=1 same cycle, no strobes.
REQ-022 MemReadIn=MemWriteIn=1 -> write cycle only, ReadData unchanged.
REQ-023 Rst_n low during 2nd READ cycle -> strobes high immediately, ReadData=0, state IDLE.
REQ-024 With LAST_WRITE_BYPASS_EN: store 0xA5A5 to 0x0008 then load 0x0008 -> ReadData=0xA5A5, 1-cycle stall, RamCE_n stays high.
